// File: rtl/pipe_ff_pkg.sv
// Package for the elastic register pipeline.
// Holds the extension-mode constants and the count-width helper shared by
// pipe_ff_elastic and its testbench.
package pipe_ff_pkg;

    // Extension modes selected by the SIGN_EXT parameter.
    localparam int unsigned EXT_ZERO = 0;
    localparam int unsigned EXT_SIGN = 1;

    // Width needed to hold a stage count in the range 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_ff_elastic_if.sv
// Handshake bus for pipe_ff_elastic.
// Upstream side : in_valid, in_data, in_ready
// Downstream side: out_valid, out_data, out_ready
// Modports:
//   slave  - the pipeline's view (takes words in, presents words out)
//   master - the environment's view (drives words in, consumes words out)
interface pipe_ff_elastic_if #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4
) ();

    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/pipe_ff_stage.sv
// One register stage of the elastic pipeline: a valid bit plus a data word.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-low clear of valid and data
//   flush     - clears valid only (data is kept)
//   load      - stage is ready; take the source valid this edge
//   src_valid - valid from the previous stage (or upstream)
//   src_data  - data from the previous stage (or extended input word)
//   valid     - registered valid bit
//   data      - registered data word
module pipe_ff_stage #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         src_valid,
    input  logic [W-1:0] src_data,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= src_valid;
            // Data only moves with a real word so an emptied stage keeps its last value.
            if (src_valid) begin
                data_q <= src_data;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_ff_elastic.sv
// Elastic, bubble-collapsing register pipeline of DEPTH stages.
// Input words are zero- or sign-extended from IN_W to OUT_W on capture
// into stage 0 and leave from stage DEPTH-1 in acceptance order.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset
//   flush - clears all in-flight words (only with PIPE_FF_FLUSH_EN)
//   bus   - valid/ready handshake bus (slave modport)
//   count - number of valid stages, 0..DEPTH
// Optional feature macro: PIPE_FF_FLUSH_EN (adds the flush port).
module pipe_ff_elastic
    import pipe_ff_pkg::*;
#(
    parameter int unsigned IN_W     = 2,
    parameter int unsigned OUT_W    = 4,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned SIGN_EXT = EXT_ZERO
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef PIPE_FF_FLUSH_EN
    input  logic                       flush,
`endif
    pipe_ff_elastic_if.slave           bus,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [OUT_W-1:0] d [DEPTH];
    logic [IN_W-1:0]  in_word;
    logic [OUT_W-1:0] cap;
    logic             flush_clr;

`ifdef PIPE_FF_FLUSH_EN
    assign flush_clr = flush;
`else
    assign flush_clr = 1'b0;
`endif

    assign in_word = bus.in_data;

    if (SIGN_EXT == EXT_SIGN) begin : g_sext
        assign cap = OUT_W'($signed(in_word));
    end else begin : g_zext
        assign cap = OUT_W'(in_word);
    end

    // Ready ripples back from the output: a stage can take a word if it is
    // empty or the stage after it can take its current word.
    always_comb begin
        logic r;
        rdy = '0;
        r   = bus.out_ready | ~v[DEPTH-1];
        rdy[DEPTH-1] = r;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            r      = r | ~v[i];
            rdy[i] = r;
        end
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        logic             src_valid;
        logic [OUT_W-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = bus.in_valid;
            assign src_data  = cap;
        end else begin : g_body
            assign src_valid = v[i-1];
            assign src_data  = d[i-1];
        end

        pipe_ff_stage #(
            .W (OUT_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush_clr),
            .load      (rdy[i]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (v[i]),
            .data      (d[i])
        );
    end

    // Handshake outputs are masked while reset or flush is active so no
    // transfer is reported in a cycle whose state is being discarded.
    assign bus.in_ready  = rdy[0] & rst & ~flush_clr;
    assign bus.out_valid = v[DEPTH-1] & rst & ~flush_clr;
    assign bus.out_data  = d[DEPTH-1];

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count = count + CNT_W'(v[i]);
        end
    end

endmodule
